subleq_lsu: RTL and testbench

//  Load/store sequencer sitting directly upstream of the 8-lane byte-interleaved MMU.

---
 rtl/subleq_lsu_if.sv | 45 ++++
 rtl/subleq_lsu.sv | 164 ++++++++++++++++
 tb/tb_subleq_lsu.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_lsu_if.sv
// Pipeline-side request/response handshake plus the MMU lane bus
// seen by the subleq load/store sequencer.
interface subleq_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  logic              mmu_en;
  logic              mmu_we;
  logic [ADDR_W-4:0] mmu_addr;
  logic [7:0]        mmu_be_n;
  logic [63:0]       mmu_wdata;
  logic [63:0]       mmu_rdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_sext, req_addr, req_wdata,
    output rsp_ready, mmu_rdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err,
    input  mmu_en, mmu_we, mmu_addr,
    input  mmu_be_n, mmu_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_sext, req_addr, req_wdata,
    input  rsp_ready, mmu_rdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err,
    output mmu_en, mmu_we, mmu_addr,
    output mmu_be_n, mmu_wdata
  );
endinterface

// File: rtl/subleq_lsu.sv
// Single-outstanding load/store sequencer in front of the
// 8-lane byte-interleaved MMU: lane enables, steering, extension.
module subleq_lsu #(
  parameter int ADDR_W   = 32,
  parameter bit SIGN_DEF = 1'b1
) (
  input logic        clk,
  input logic        reset,
  subleq_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic        accept;
  logic        misalign;
  logic        unmapped;
  logic        bad;
  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wd_shift;
  logic [63:0] wd_lane;
  logic [63:0] rd_shift;
  logic [63:0] rd_ext;

  logic        we_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [2:0]  off_q;

  assign off      = bus.req_addr[2:0];
  assign unmapped = bus.req_addr[ADDR_W-1];
  assign bad      = misalign | unmapped;

  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h01;
    unique case (bus.req_size)
      2'b00: begin
        misalign  = 1'b0;
        size_mask = 8'h01;
      end
      2'b01: begin
        misalign  = off[0];
        size_mask = 8'h03;
      end
      2'b10: begin
        misalign  = |off[1:0];
        size_mask = 8'h0F;
      end
      default: begin
        misalign  = |off;
        size_mask = 8'hFF;
      end
    endcase
  end

  // Aligned accesses never spill past lane 7, so a plain shift suffices.
  assign lane_mask = size_mask << off;
  assign wd_shift  = bus.req_wdata << {off, 3'b000};

  always_comb begin
    wd_lane = '0;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i])
        wd_lane[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

  assign rd_shift = bus.mmu_rdata >> {off_q, 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    unique case (size_q)
      2'b00: rd_ext = {{56{sext_q & rd_shift[7]}},
                       rd_shift[7:0]};
      2'b01: rd_ext = {{48{sext_q & rd_shift[15]}},
                       rd_shift[15:0]};
      2'b10: rd_ext = {{32{sext_q & rd_shift[31]}},
                       rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = bad ? RESP : ISSUE;
        end
      end
      ISSUE:   state_nx = we_q ? RESP : WAIT;
      WAIT:    state_nx = RESP;
      default: begin
        if (bus.rsp_ready)
          state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mmu_en    <= 1'b0;
      bus.mmu_we    <= 1'b0;
      bus.mmu_addr  <= '0;
      bus.mmu_be_n  <= 8'hFF;
      bus.mmu_wdata <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      we_q          <= 1'b0;
      sext_q        <= SIGN_DEF;
      size_q        <= 2'b00;
      off_q         <= 3'b000;
    end else begin
      bus.mmu_en   <= accept & ~bad;
      bus.mmu_we   <= accept & ~bad & bus.req_we;
      bus.mmu_be_n <= (accept & ~bad) ? ~lane_mask : 8'hFF;
      if (accept & ~bad) begin
        bus.mmu_addr  <= bus.req_addr[ADDR_W-1:3];
        bus.mmu_wdata <= wd_lane;
      end
      if (accept) begin
        we_q   <= bus.req_we;
        sext_q <= bus.req_sext;
        size_q <= bus.req_size;
        off_q  <= off;
      end
      if (accept & bad) begin
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end
      if (state == ISSUE && we_q) begin
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
      // Read data is valid on the MMU bus only during WAIT.
      if (state == WAIT) begin
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_subleq_lsu.sv
// Bench for subleq_lsu: word-level MMU model plus a byte-level
// reference memory, directed cases then random traffic.
module tb_subleq_lsu;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  subleq_lsu_if #(.ADDR_W(32)) bus();

  subleq_lsu #(
    .ADDR_W(32),
    .SIGN_DEF(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [63:0] mmu_mem [0:127];

  int          en_cnt = 0;
  int          idle_bad = 0;
  int          cyc = 0;
  logic        last_we;
  logic [28:0] last_addr;
  logic [7:0]  last_be_n;
  logic [63:0] last_wdata;
  logic [63:0] rsp_seen;

  // MMU: byte-lane writes, read data the cycle after an enabled read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mmu_en === 1'b1) begin
      en_cnt     <= en_cnt + 1;
      last_we    <= bus.mmu_we;
      last_addr  <= bus.mmu_addr;
      last_be_n  <= bus.mmu_be_n;
      last_wdata <= bus.mmu_wdata;
      if (bus.mmu_we) begin
        for (int i = 0; i < 8; i++)
          if (!bus.mmu_be_n[i])
            mmu_mem[bus.mmu_addr[6:0]][8*i +: 8] <=
              bus.mmu_wdata[8*i +: 8];
        bus.mmu_rdata <= {$urandom(), $urandom()};
      end else begin
        bus.mmu_rdata <= mmu_mem[bus.mmu_addr[6:0]];
      end
    end else begin
      bus.mmu_rdata <= {$urandom(), $urandom()};
      if (!reset && (bus.mmu_be_n !== 8'hFF ||
                     bus.mmu_we !== 1'b0))
        idle_bad <= idle_bad + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(
    input logic [31:0] a, input int n, input bit sx);
    logic [63:0] v;
    bit neg;
    v = '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = ref_mem[(int'(a[9:0]) + i) % 1024];
    neg = sx && v[8*n-1];
    for (int i = n; i < 8; i++)
      v[8*i +: 8] = neg ? 8'hFF : 8'h00;
    return v;
  endfunction

  task automatic do_req(input bit we, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a,
                        input logic [63:0] wd, input int hold);
    int n, lane, e0, w, lat, elat;
    bit err;
    logic [63:0] exp_rd, exp_wd;
    logic [7:0] exp_ben;
    n = 1 << sz;
    err = ((int'(a[2:0]) % n) != 0) || a[31];
    exp_rd = '0;
    exp_wd = '0;
    exp_ben = 8'hFF;
    if (!err && !we) exp_rd = ref_load(a, n, sx);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        lane = (int'(a[2:0]) + i) % 8;
        exp_ben[lane] = 1'b0;
        exp_wd[8*lane +: 8] = wd[8*i +: 8];
      end
    end
    elat = err ? 1 : (we ? 2 : 3);
    e0 = en_cnt;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_sext  = sx;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("rsp_err", 64'(bus.rsp_err), 64'(err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    rsp_seen = bus.rsp_rdata;
    // A competing request while the response is held must be ignored.
    bus.req_valid = (hold > 0);
    bus.req_addr  = 32'h0000_0010;
    bus.req_size  = 2'b00;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 64'(bus.rsp_err), 64'(err));
      chk("hold_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("done_ready", 64'(bus.req_ready), 64'(1));
    chk("done_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mmu_pulses", 64'(en_cnt - e0), 64'(err ? 0 : 1));
    if (!err) begin
      chk("mmu_we", 64'(last_we), 64'(we));
      chk("mmu_addr", 64'(last_addr), 64'(a[31:3]));
      chk("mmu_be_n", 64'(last_be_n), 64'(exp_ben));
      if (we) begin
        chk("mmu_wdata", last_wdata, exp_wd);
        for (int i = 0; i < n; i++)
          ref_mem[(int'(a[9:0]) + i) % 1024] = wd[8*i +: 8];
      end
    end
  endtask

  initial begin
    int e0, w, n;
    int acc [0:3];
    logic [31:0] a;
    logic [63:0] wd;
    logic [1:0]  sz;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 128; i++) mmu_mem[i] = 64'h0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
    chk("rst_mmu_en", 64'(bus.mmu_en), 64'(0));
    chk("rst_mmu_we", 64'(bus.mmu_we), 64'(0));
    chk("rst_mmu_addr", 64'(bus.mmu_addr), 64'h0);
    chk("rst_mmu_be_n", 64'(bus.mmu_be_n), 64'hFF);
    chk("rst_mmu_wdata", bus.mmu_wdata, 64'h0);
    reset = 1'b0;

    do_req(1'b1, 2'b11, 1'b0, 32'h40,
           64'h1122334455667788, 0);
    chk("st64_addr", 64'(last_addr), 64'd8);
    chk("st64_be_n", 64'(last_be_n), 64'h00);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 64'h0, 0);
    chk("ld64_data", rsp_seen, 64'h1122334455667788);

    do_req(1'b1, 2'b00, 1'b0, 32'h45,
           64'hABCD_0000_0000_0080, 0);
    chk("stb_be_n", 64'(last_be_n), 64'hDF);
    chk("stb_lane5", 64'(last_wdata[47:40]), 64'h80);
    do_req(1'b0, 2'b00, 1'b1, 32'h45, 64'h0, 0);
    chk("ldb_sext", rsp_seen, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h45, 64'h0, 0);
    chk("ldb_zext", rsp_seen, 64'h80);

    do_req(1'b1, 2'b00, 1'b0, 32'h47, 64'h5A, 0);
    chk("stb7_be_n", 64'(last_be_n), 64'h7F);

    do_req(1'b0, 2'b01, 1'b0, 32'h43, 64'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h8000_0000, 64'h0, 0);

    do_req(1'b1, 2'b10, 1'b0, 32'h4C,
           64'hCAFE_F00D_DEAD_BEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h4C, 64'h0, 5);
    chk("bp_data", rsp_seen, 64'h0000_0000_DEAD_BEEF);

    // Reset while the load sits in WAIT.
    e0 = en_cnt;
    @(negedge clk);
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b11;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h40;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mid_req_ready", 64'(bus.req_ready), 64'(1));
    chk("mid_be_n", 64'(bus.mmu_be_n), 64'hFF);
    chk("mid_mmu_en", 64'(bus.mmu_en), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("mid_idle", 64'(bus.req_ready), 64'(1));
    chk("mid_pulses", 64'(en_cnt - e0), 64'(1));

    // Back-to-back dword stores with req_valid held high.
    e0 = en_cnt;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a  = 32'h100 + 32'(8 * k);
      wd = {$urandom(), $urandom()};
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b11;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      acc[k] = cyc;
      for (int i = 0; i < 8; i++)
        ref_mem[int'(a[9:0]) + i] = wd[8*i +: 8];
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    for (int k = 1; k < 4; k++)
      chk("b2b_period", 64'(acc[k] - acc[k-1]), 64'd3);
    chk("b2b_pulses", 64'(en_cnt - e0), 64'd4);

    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      a  = {($urandom_range(0, 7) == 0), 21'b0,
            10'($urandom())};
      if ($urandom_range(0, 3) != 0)
        a[2:0] = a[2:0] & ~3'(n - 1);
      do_req(1'($urandom()), sz, 1'($urandom()), a,
             {$urandom(), $urandom()},
             $urandom_range(0, 2));
    end

    chk("idle_mmu_outputs", 64'(idle_bad), 64'(0));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
